// File: rtl/loader_pkg.sv
// Shared constants and state encodings for the serial instruction-memory loader.
package loader_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DATA  = 2'd2,
    CHECK = 2'd3
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, bit-centre sampling, one-cycle
// byte_valid / frame_bad pulses.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_bad
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic          fall_c;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          bad_q, bad_d;

  // Synchronize the asynchronous line; idle level is high.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Only a true high-to-low transition starts a frame, so a held-low line
  // after a broken stop bit does not retrigger.
  assign fall_c = rx_prev_q & ~rx_sync_q;

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
    end
  end

  // Next-state: half-bit start check, then full-bit sampling of data and stop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    bad_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall_c) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync_q) valid_d = 1'b1;
          else           bad_d   = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign frame_bad  = bad_q;
  assign rx_byte    = shift_q;

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: parses A5 / count / big-endian words [/ checksum]
// from the UART and writes instruction memory, holding the CPU meanwhile.
// Optional trailing XOR checksum enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned MAX_WORDS    = 64,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        rx,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        load_err
);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_bad;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .nRST      (nRST),
    .rx        (rx),
    .byte_valid(rx_valid),
    .rx_byte   (rx_data),
    .frame_bad (rx_bad)
  );

  ld_state_e   state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] asm_q, asm_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        hold_q, hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        abort_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  // Loader state, assembly and output registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      bcnt_q    <= '0;
      asm_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= '0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      asm_q     <= asm_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Next-state and output decode; aborts leave cpu_hold asserted.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    asm_d     = asm_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    abort_c   = rx_bad && (state_q != IDLE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_valid && rx_data == HDR_BYTE) begin
          hold_d  = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          bcnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (rx_valid) begin
          if (rx_data != 8'd0 && 32'(rx_data) <= MAX_WORDS) begin
            n_d     = rx_data;
            state_d = DATA;
          end else begin
            abort_c = 1'b1;
          end
        end
      end
      DATA: begin
        if (idx_q == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          done_d  = 1'b1;
          busy_d  = 1'b0;
          hold_d  = 1'b0;
          state_d = IDLE;
`endif
        end else if (rx_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = {asm_q, rx_data};
            wr_addr_d = BASE_ADDR + (32'(idx_q) << 2);
            idx_d     = idx_q + 8'd1;
          end else begin
            asm_d = {asm_q[15:0], rx_data};
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            hold_d  = 1'b0;
            state_d = IDLE;
          end else begin
            abort_c = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (abort_c) begin
      err_d   = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign load_err = err_q;

endmodule
